// File: rtl/sm_mem_arbiter_if.sv
// sm_mem_arbiter_if
//  Bundles the three buses around the unified-memory arbiter:
//    I port  : i_req, i_addr -> i_ack, i_rvalid, i_rdata   (instruction fetch)
//    D port  : d_req, d_we, d_addr, d_wdata -> d_ack, d_rvalid, d_rdata (load/store)
//    Memory  : m_en, m_we, m_addr, m_wdata -> m_rdata     (single-port sync RAM)
//  Modports:
//    slave  : the arbiter's view (takes requests and read data, drives acks,
//             returned data and the memory strobe)
//    master : the surrounding system's view (CPU ports plus memory model)
interface sm_mem_arbiter_if #(
  parameter int AW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic          i_rvalid;
  logic [31:0]   i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_ack;
  logic          d_rvalid;
  logic [31:0]   d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/sm_mem_arbiter.sv
// sm_mem_arbiter
//  Shares one single-port synchronous memory between the CPU fetch (I) port
//  and the load/store (D) port, so the core can run from one unified RAM.
//  At most one read is outstanding; its data is steered back to the port that
//  issued it exactly RD_LAT cycles after the accept. Writes (D only) complete
//  in their accept cycle.
//  Parameters:
//    AW       word-address width
//    RD_LAT   memory read latency in cycles (1..7)
//    ARB_MODE 0 = round-robin between I and D, 1 = D always wins
//  Ports:
//    clk  clock, all state changes on its rising edge
//    rst  synchronous active-high reset
//    bus  sm_mem_arbiter_if.slave: I/D request ports and the memory port
module sm_mem_arbiter #(
  parameter int AW       = 32,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  sm_mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
    $error("sm_mem_arbiter: RD_LAT=%0d is outside the legal range 1..7", RD_LAT);
  end

  state_t        state;
  logic [2:0]    cnt;
  logic          owner_d;
  logic          last_d;

  logic          window;
  logic          grant_i;
  logic          grant_d;
  logic          grant_wr;
  logic          rd_done;
  logic [AW-1:0] addr_sel;

  // A new access may only be issued once the previous read's data is due,
  // which is also the cycle that data is handed back. Nothing is issued or
  // returned during a reset cycle, so an abandoned read can never surface.
  always_comb begin
    window  = (state == IDLE) || (cnt == 3'd0);
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst && window) begin
      if (bus.i_req && bus.d_req) begin
        if (ARB_MODE != 0 || !last_d) grant_d = 1'b1;
        else                          grant_i = 1'b1;
      end else begin
        grant_i = bus.i_req;
        grant_d = bus.d_req;
      end
    end
    grant_wr = grant_d && bus.d_we;
    rd_done  = !rst && (state == WAIT) && (cnt == 3'd0);
    if (grant_i)      addr_sel = bus.i_addr;
    else if (grant_d) addr_sel = bus.d_addr;
    else              addr_sel = '0;
  end

  assign bus.i_ack    = grant_i;
  assign bus.d_ack    = grant_d;
  assign bus.m_en     = grant_i || grant_d;
  assign bus.m_we     = grant_wr;
  assign bus.m_addr   = addr_sel;
  assign bus.m_wdata  = grant_wr ? bus.d_wdata : 32'd0;

  // Read data is a straight pass-through of the memory, gated to the owner.
  assign bus.i_rvalid = rd_done && !owner_d;
  assign bus.d_rvalid = rd_done &&  owner_d;
  assign bus.i_rdata  = (rd_done && !owner_d) ? bus.m_rdata : 32'd0;
  assign bus.d_rdata  = (rd_done &&  owner_d) ? bus.m_rdata : 32'd0;

  // A read grant starts the latency countdown; a write leaves the arbiter
  // free for the very next cycle. last_d starts at D so the first conflict
  // in round-robin mode goes to I.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      owner_d <= 1'b0;
      last_d  <= 1'b1;
    end else if (grant_i || grant_d) begin
      last_d <= grant_d;
      if (grant_wr) begin
        state <= IDLE;
        cnt   <= 3'd0;
      end else begin
        state   <= WAIT;
        cnt     <= CNT_INIT;
        owner_d <= grant_d;
      end
    end else if (state == WAIT) begin
      if (cnt != 3'd0) cnt   <= cnt - 3'd1;
      else             state <= IDLE;
    end
  end

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// tb_sm_mem_arbiter
//  Drives four arbiter instances with different latency / arbitration settings
//  from one sequence of directed and randomized steps. A cycle-numbered
//  reference model (issue-allowed-from cycle, one pending read with its due
//  cycle, a word array) predicts every output of every instance each cycle.
module tb_sm_mem_arbiter;

  localparam int NDUT = 4;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      2:       return 3;
      default: return 7;
    endcase
  endfunction

  function automatic int mode_of(input int k);
    return (k == 1 || k == 3) ? 1 : 0;
  endfunction

  function automatic logic [31:0] init_word(input int k, input int a);
    if (a == 16) return 32'h2408_0005;
    return (32'h9E37_79B9 * 32'(a + 1)) ^ 32'(k << 28);
  endfunction

  typedef struct packed {
    logic        i_ack;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_ack;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0] rst;
  logic [NDUT-1:0] i_req;
  logic [NDUT-1:0] d_req;
  logic [NDUT-1:0] d_we;
  logic [31:0]     i_addr  [NDUT];
  logic [31:0]     d_addr  [NDUT];
  logic [31:0]     d_wdata [NDUT];
  logic [31:0]     m_rdata [NDUT];

  wire [NDUT-1:0]  o_i_ack, o_i_rvalid, o_d_ack, o_d_rvalid, o_m_en, o_m_we;
  wire [31:0]      o_i_rdata [NDUT];
  wire [31:0]      o_d_rdata [NDUT];
  wire [31:0]      o_m_addr  [NDUT];
  wire [31:0]      o_m_wdata [NDUT];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    sm_mem_arbiter_if #(.AW(32)) bus ();

    assign bus.i_req   = i_req[k];
    assign bus.i_addr  = i_addr[k];
    assign bus.d_req   = d_req[k];
    assign bus.d_we    = d_we[k];
    assign bus.d_addr  = d_addr[k];
    assign bus.d_wdata = d_wdata[k];
    assign bus.m_rdata = m_rdata[k];

    assign o_i_ack[k]    = bus.i_ack;
    assign o_i_rvalid[k] = bus.i_rvalid;
    assign o_i_rdata[k]  = bus.i_rdata;
    assign o_d_ack[k]    = bus.d_ack;
    assign o_d_rvalid[k] = bus.d_rvalid;
    assign o_d_rdata[k]  = bus.d_rdata;
    assign o_m_en[k]     = bus.m_en;
    assign o_m_we[k]     = bus.m_we;
    assign o_m_addr[k]   = bus.m_addr;
    assign o_m_wdata[k]  = bus.m_wdata;

    sm_mem_arbiter #(
      .AW      (32),
      .RD_LAT  (lat_of(k)),
      .ARB_MODE(mode_of(k))
    ) dut (
      .clk(clk),
      .rst(rst[k]),
      .bus(bus)
    );
  end

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // reference model state
  int          next_issue [NDUT];
  bit          last_d     [NDUT];
  bit          pend_v     [NDUT];
  int          pend_due   [NDUT];
  bit          pend_d     [NDUT];
  logic [31:0] pend_addr  [NDUT];
  logic [31:0] rmem       [NDUT][256];

  // environment memory (answers the DUT's strobes)
  logic [31:0] emem       [NDUT][256];
  bit          pv         [NDUT][8];
  logic [7:0]  pa         [NDUT][8];

  out_t        s_out      [NDUT];
  int          auto_i     [NDUT];
  int          auto_d     [NDUT];
  int          wr_pct     [NDUT];

  task automatic checkOutput(input string tag, input out_t obs, input out_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic out_t obs_of(input int k);
    out_t o;
    o.i_ack    = o_i_ack[k];
    o.i_rvalid = o_i_rvalid[k];
    o.i_rdata  = o_i_rdata[k];
    o.d_ack    = o_d_ack[k];
    o.d_rvalid = o_d_rvalid[k];
    o.d_rdata  = o_d_rdata[k];
    o.m_en     = o_m_en[k];
    o.m_we     = o_m_we[k];
    o.m_addr   = o_m_addr[k];
    o.m_wdata  = o_m_wdata[k];
    return o;
  endfunction

  // Predict this cycle's outputs of instance k, compare, then advance the model.
  task automatic modelCycle(input int k);
    out_t exp;
    out_t obs;
    bit   gi, gd;
    exp = '0;
    if (rst[k]) begin
      next_issue[k] = cyc + 1;
      pend_v[k]     = 1'b0;
      last_d[k]     = 1'b1;
    end else begin
      if (pend_v[k] && pend_due[k] == cyc) begin
        if (pend_d[k]) begin
          exp.d_rvalid = 1'b1;
          exp.d_rdata  = rmem[k][pend_addr[k][7:0]];
        end else begin
          exp.i_rvalid = 1'b1;
          exp.i_rdata  = rmem[k][pend_addr[k][7:0]];
        end
        pend_v[k] = 1'b0;
      end
      if (cyc >= next_issue[k]) begin
        gi = i_req[k];
        gd = d_req[k];
        if (gi && gd) begin
          if (mode_of(k) == 1 || !last_d[k]) gi = 1'b0;
          else                               gd = 1'b0;
        end
        if (gi) begin
          exp.i_ack  = 1'b1;
          exp.m_en   = 1'b1;
          exp.m_addr = i_addr[k];
          pend_v[k] = 1'b1; pend_d[k] = 1'b0; pend_addr[k] = i_addr[k];
          pend_due[k] = cyc + lat_of(k); next_issue[k] = cyc + lat_of(k);
          last_d[k] = 1'b0;
        end
        if (gd) begin
          exp.d_ack  = 1'b1;
          exp.m_en   = 1'b1;
          exp.m_addr = d_addr[k];
          if (d_we[k]) begin
            exp.m_we    = 1'b1;
            exp.m_wdata = d_wdata[k];
            rmem[k][d_addr[k][7:0]] = d_wdata[k];
            next_issue[k] = cyc + 1;
          end else begin
            pend_v[k] = 1'b1; pend_d[k] = 1'b1; pend_addr[k] = d_addr[k];
            pend_due[k] = cyc + lat_of(k); next_issue[k] = cyc + lat_of(k);
          end
          last_d[k] = 1'b1;
        end
      end
    end
    obs = obs_of(k);
    checkOutput($sformatf("dut%0d cycle %0d outputs", k, cyc), obs, exp);
    s_out[k] = obs;
  endtask

  // After the clock edge: memory answers strobes, acked requests are retired,
  // and random requesters may raise new requests.
  task automatic applyStimulus(input int k);
    for (int s = 7; s > 0; s--) begin
      pv[k][s] = pv[k][s-1];
      pa[k][s] = pa[k][s-1];
    end
    pv[k][0] = s_out[k].m_en && !s_out[k].m_we;
    pa[k][0] = s_out[k].m_addr[7:0];
    if (s_out[k].m_en && s_out[k].m_we) emem[k][s_out[k].m_addr[7:0]] = s_out[k].m_wdata;
    m_rdata[k] = pv[k][lat_of(k)-1] ? emem[k][pa[k][lat_of(k)-1]] : 32'hBADD_F00D;

    if (s_out[k].i_ack) i_req[k] = 1'b0;
    if (s_out[k].d_ack) d_req[k] = 1'b0;
    if (!i_req[k] && auto_i[k] > 0 && $urandom_range(99) < auto_i[k]) begin
      i_req[k]  = 1'b1;
      i_addr[k] = $urandom;
    end
    if (!d_req[k] && auto_d[k] > 0 && $urandom_range(99) < auto_d[k]) begin
      d_req[k]   = 1'b1;
      d_we[k]    = ($urandom_range(99) < wr_pct[k]);
      d_addr[k]  = $urandom;
      d_wdata[k] = $urandom;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) modelCycle(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) applyStimulus(k);
    cyc++;
  endtask

  task automatic reqI(input int k, input logic [31:0] a);
    i_req[k]  = 1'b1;
    i_addr[k] = a;
  endtask

  task automatic reqD(input int k, input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_req[k]   = 1'b1;
    d_we[k]    = we;
    d_addr[k]  = a;
    d_wdata[k] = wd;
  endtask

  task automatic waitAck(input int k, input bit port_d, input int bound);
    bit seen = 1'b0;
    for (int n = 0; n < bound && !seen; n++) begin
      tick();
      seen = port_d ? s_out[k].d_ack : s_out[k].i_ack;
    end
    checkValue($sformatf("dut%0d ack within %0d cycles", k, bound), 32'(seen), 32'd1);
  endtask

  task automatic waitRvalid(input int k, input bit port_d, input int bound,
                            output int lat_seen, output logic [31:0] data);
    bit seen = 1'b0;
    lat_seen = -1;
    data     = '0;
    for (int n = 1; n <= bound && !seen; n++) begin
      tick();
      seen = port_d ? s_out[k].d_rvalid : s_out[k].i_rvalid;
      if (seen) begin
        lat_seen = n;
        data     = port_d ? s_out[k].d_rdata : s_out[k].i_rdata;
      end
    end
    checkValue($sformatf("dut%0d rvalid within %0d cycles", k, bound), 32'(seen), 32'd1);
  endtask

  task automatic drainAll();
    for (int n = 0; n < 100 && ((|i_req) || (|d_req)); n++) tick();
    checkValue("requests drained", 32'((|i_req) || (|d_req)), 32'd0);
    repeat (10) tick();
  endtask

  initial begin
    int          lat_seen;
    logic [31:0] data;
    bit          prev_d;
    bit          port_d;
    bit          seen;
    int          last_ack;

    rst   = '1;
    i_req = '0;
    d_req = '0;
    d_we  = '0;
    for (int k = 0; k < NDUT; k++) begin
      i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0; m_rdata[k] = '0;
      auto_i[k] = 0; auto_d[k] = 0; wr_pct[k] = 0;
      next_issue[k] = 0; last_d[k] = 1'b1; pend_v[k] = 1'b0;
      pend_due[k] = 0; pend_d[k] = 1'b0; pend_addr[k] = '0;
      s_out[k] = '0;
      for (int s = 0; s < 8; s++) begin
        pv[k][s] = 1'b0;
        pa[k][s] = '0;
      end
      for (int a = 0; a < 256; a++) begin
        rmem[k][a] = init_word(k, a);
        emem[k][a] = init_word(k, a);
      end
    end

    $display("[TB] reset and idle");
    tick();
    tick();
    rst = '0;
    repeat (4) tick();

    $display("[TB] single fetch, RD_LAT=1");
    reqI(1, 32'h10);
    waitAck(1, 1'b0, 10);
    tick();
    checkValue("single fetch i_rvalid", 32'(s_out[1].i_rvalid), 32'd1);
    checkValue("single fetch i_rdata", s_out[1].i_rdata, 32'h2408_0005);
    checkValue("single fetch d side quiet",
               32'(s_out[1].d_ack || s_out[1].d_rvalid || (s_out[1].d_rdata != 0)), 32'd0);

    $display("[TB] first conflict and round-robin, RD_LAT=2");
    reqI(0, 32'h40);
    reqD(0, 1'b0, 32'h44, 32'h0);
    tick();
    checkValue("first conflict grants I", 32'(s_out[0].i_ack), 32'd1);
    checkValue("first conflict holds D", 32'(s_out[0].d_ack), 32'd0);
    auto_i[0] = 100;
    auto_d[0] = 100;
    wr_pct[0] = 0;
    prev_d    = 1'b0;
    last_ack  = cyc - 1;
    repeat (12) begin
      tick();
      if (s_out[0].i_ack || s_out[0].d_ack) begin
        port_d = s_out[0].d_ack;
        checkValue("round-robin alternation", 32'(port_d), 32'(!prev_d));
        checkValue("round-robin spacing", 32'(cyc - 1 - last_ack), 32'd2);
        prev_d   = port_d;
        last_ack = cyc - 1;
      end
    end
    auto_i[0] = 0;
    auto_d[0] = 0;
    drainAll();

    $display("[TB] write then read on D");
    reqD(0, 1'b1, 32'h20, 32'hDEAD_BEEF);
    waitAck(0, 1'b1, 10);
    tick();
    checkValue("write gives no d_rvalid", 32'(s_out[0].d_rvalid), 32'd0);
    reqD(0, 1'b0, 32'h20, 32'h0);
    waitAck(0, 1'b1, 10);
    waitRvalid(0, 1'b1, 10, lat_seen, data);
    checkValue("read-after-write data", data, 32'hDEAD_BEEF);
    checkValue("read latency RD_LAT=2", 32'(lat_seen), 32'd2);

    $display("[TB] fixed priority with I held");
    auto_i[1] = 100;
    repeat (3) begin
      repeat (2) tick();
      reqD(1, 1'b0, $urandom, 32'h0);
      tick();
      checkValue("fixed priority D granted", 32'(s_out[1].d_ack), 32'd1);
      checkValue("fixed priority I waits", 32'(s_out[1].i_ack), 32'd0);
    end
    repeat (2) tick();
    auto_i[1] = 0;
    drainAll();

    $display("[TB] reset mid-read, RD_LAT=3");
    reqI(2, 32'h80);
    waitAck(2, 1'b0, 10);
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (s_out[2].i_rvalid) seen = 1'b1;
    end
    checkValue("no rvalid after reset", 32'(seen), 32'd0);
    reqI(2, 32'h80);
    waitAck(2, 1'b0, 10);
    waitRvalid(2, 1'b0, 10, lat_seen, data);
    checkValue("re-issued fetch data", data, init_word(2, 32'h80));
    checkValue("re-issued fetch latency", 32'(lat_seen), 32'd3);

    $display("[TB] max latency fetch, RD_LAT=7");
    reqI(3, 32'h10);
    waitAck(3, 1'b0, 10);
    waitRvalid(3, 1'b0, 12, lat_seen, data);
    checkValue("RD_LAT=7 fetch data", data, 32'h2408_0005);
    checkValue("RD_LAT=7 fetch latency", 32'(lat_seen), 32'd7);

    $display("[TB] randomized traffic");
    for (int k = 0; k < NDUT; k++) begin
      auto_i[k] = 60;
      auto_d[k] = 60;
      wr_pct[k] = 40;
    end
    repeat (600) tick();
    for (int k = 0; k < NDUT; k++) begin
      auto_i[k] = 0;
      auto_d[k] = 0;
    end
    drainAll();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
